// File: rtl/energy_squelch_pkg.sv
// rtl/energy_squelch_pkg.sv - shared state encoding, default widths and saturating increment
package energy_squelch_pkg;

    localparam int ENERGY_W_DEF = 8;
    localparam int ATTACK_W_DEF = 8;
    localparam int HANG_W_DEF   = 16;
    localparam int EVENT_W_DEF  = 16;

    typedef enum logic [1:0] {
        ST_CLOSED = 2'd0,
        ST_ATTACK = 2'd1,
        ST_OPEN   = 2'd2,
        ST_HANG   = 2'd3
    } sq_state_t;

    // Works on a 64-bit carrier so one function serves every counter width up to 64
    function automatic logic [63:0] sat_inc(input logic [63:0] v, input int unsigned w);
        logic [63:0] mask;
        mask = (w >= 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
        return (v >= mask) ? mask : v + 64'd1;
    endfunction

endpackage

// File: rtl/energy_squelch_if.sv
// rtl/energy_squelch_if.sv - energy input, configuration and squelch status bundle
interface energy_squelch_if #(
    parameter int ENERGY_W = 8,
    parameter int ATTACK_W = 8,
    parameter int HANG_W   = 16,
    parameter int EVENT_W  = 16
);
    logic [ENERGY_W-1:0] Energy;
    logic [ENERGY_W-1:0] OnThreshold;
    logic [ENERGY_W-1:0] OffThreshold;
    logic [ATTACK_W-1:0] AttackCount;
    logic [HANG_W-1:0]   HangCount;
    logic                Open;
    logic                OpenPulse;
    logic                ClosePulse;
    logic [ENERGY_W-1:0] Peak;
    logic [EVENT_W-1:0]  EventCount;

    modport slave (
        input  Energy, OnThreshold, OffThreshold, AttackCount, HangCount,
        output Open, OpenPulse, ClosePulse, Peak, EventCount
    );

    modport master (
        output Energy, OnThreshold, OffThreshold, AttackCount, HangCount,
        input  Open, OpenPulse, ClosePulse, Peak, EventCount
    );
endinterface

// File: rtl/energy_squelch_sat_counter.sv
// rtl/energy_squelch_sat_counter.sv - up counter with clear and enable that sticks at all-ones
module energy_squelch_sat_counter
    import energy_squelch_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_clr,
    input  logic         i_en,
    output logic [W-1:0] o_q
);
    logic [W-1:0] r_q;

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) begin
            r_q <= '0;
        end else if (i_en) begin
            r_q <= W'(sat_inc(64'(r_q), W));
        end
    end

    assign o_q = r_q;
endmodule

// File: rtl/energy_squelch.sv
// rtl/energy_squelch.sv - attack/hang hysteresis squelch on the 8-bit energy estimate
module energy_squelch
    import energy_squelch_pkg::*;
#(
    parameter int ENERGY_W = ENERGY_W_DEF,
    parameter int ATTACK_W = ATTACK_W_DEF,
    parameter int HANG_W   = HANG_W_DEF,
    parameter int EVENT_W  = EVENT_W_DEF
) (
    input  logic             Clk_780k,
    input  logic             Reset,
    energy_squelch_if.slave  sq
);
    sq_state_t           r_state;
    sq_state_t           w_state_nxt;
    logic                r_open;
    logic                r_open_pulse;
    logic                r_close_pulse;
    logic [ENERGY_W-1:0] r_peak;

    logic                w_on;
    logic                w_rel;
    logic                w_att_clr, w_att_en;
    logic                w_hang_clr, w_hang_en;
    logic                w_enter_open, w_enter_close;
    logic [ATTACK_W-1:0] w_att_q, w_att_inc, w_att_eff;
    logic [HANG_W-1:0]   w_hang_q, w_hang_inc;
    logic [EVENT_W-1:0]  w_event_q;

    assign w_on       = (sq.Energy >= sq.OnThreshold);
    assign w_rel      = (sq.Energy <  sq.OffThreshold);
    assign w_att_eff  = (sq.AttackCount == '0) ? ATTACK_W'(1) : sq.AttackCount;
    assign w_att_inc  = ATTACK_W'(sat_inc(64'(w_att_q), ATTACK_W));
    assign w_hang_inc = HANG_W'(sat_inc(64'(w_hang_q), HANG_W));

    always_ff @(posedge Clk_780k) begin
        if (Reset) begin
            r_state <= ST_CLOSED;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // CLOSED and ATTACK share the qualify path: the attack counter is zero while closed
    always_comb begin
        w_state_nxt   = r_state;
        w_att_clr     = 1'b0;
        w_att_en      = 1'b0;
        w_hang_clr    = 1'b0;
        w_hang_en     = 1'b0;
        w_enter_open  = 1'b0;
        w_enter_close = 1'b0;
        case (r_state)
            ST_CLOSED, ST_ATTACK: begin
                if (!w_on) begin
                    w_state_nxt = ST_CLOSED;
                    w_att_clr   = 1'b1;
                end else if (w_att_inc >= w_att_eff) begin
                    w_state_nxt  = ST_OPEN;
                    w_att_clr    = 1'b1;
                    w_enter_open = 1'b1;
                end else begin
                    w_state_nxt = ST_ATTACK;
                    w_att_en    = 1'b1;
                end
            end
            ST_OPEN: begin
                if (w_rel) begin
                    if (sq.HangCount == '0) begin
                        w_state_nxt   = ST_CLOSED;
                        w_hang_clr    = 1'b1;
                        w_enter_close = 1'b1;
                    end else begin
                        w_state_nxt = ST_HANG;
                        w_hang_en   = 1'b1;
                    end
                end
            end
            ST_HANG: begin
                if (!w_rel) begin
                    w_state_nxt = ST_OPEN;
                    w_hang_clr  = 1'b1;
                end else if (w_hang_inc >= sq.HangCount) begin
                    w_state_nxt   = ST_CLOSED;
                    w_hang_clr    = 1'b1;
                    w_enter_close = 1'b1;
                end else begin
                    w_hang_en = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_CLOSED;
                w_att_clr   = 1'b1;
                w_hang_clr  = 1'b1;
            end
        endcase
    end

    always_ff @(posedge Clk_780k) begin
        if (Reset) begin
            r_open        <= 1'b0;
            r_open_pulse  <= 1'b0;
            r_close_pulse <= 1'b0;
            r_peak        <= '0;
        end else begin
            r_open        <= (w_state_nxt == ST_OPEN) || (w_state_nxt == ST_HANG);
            r_open_pulse  <= w_enter_open;
            r_close_pulse <= w_enter_close;
            if (w_enter_open) begin
                r_peak <= sq.Energy;
            end else if (((r_state == ST_OPEN) || (r_state == ST_HANG)) && (sq.Energy > r_peak)) begin
                r_peak <= sq.Energy;
            end
        end
    end

    energy_squelch_sat_counter #(.W(ATTACK_W)) u_attack_cnt (
        .i_clk (Clk_780k),
        .i_rst (Reset),
        .i_clr (w_att_clr),
        .i_en  (w_att_en),
        .o_q   (w_att_q)
    );

    energy_squelch_sat_counter #(.W(HANG_W)) u_hang_cnt (
        .i_clk (Clk_780k),
        .i_rst (Reset),
        .i_clr (w_hang_clr),
        .i_en  (w_hang_en),
        .o_q   (w_hang_q)
    );

    energy_squelch_sat_counter #(.W(EVENT_W)) u_event_cnt (
        .i_clk (Clk_780k),
        .i_rst (Reset),
        .i_clr (1'b0),
        .i_en  (w_enter_open),
        .o_q   (w_event_q)
    );

    assign sq.Open       = r_open;
    assign sq.OpenPulse  = r_open_pulse;
    assign sq.ClosePulse = r_close_pulse;
    assign sq.Peak       = r_peak;
    assign sq.EventCount = w_event_q;
endmodule

// File: tb/tb_energy_squelch.sv
// tb/tb_energy_squelch.sv - scoreboard bench for energy_squelch with a 2-bit event counter twin
module tb_energy_squelch;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    energy_squelch_if #(.ENERGY_W(8), .ATTACK_W(8), .HANG_W(16), .EVENT_W(16)) sq_a ();
    energy_squelch_if #(.ENERGY_W(8), .ATTACK_W(8), .HANG_W(16), .EVENT_W(2))  sq_b ();

    energy_squelch #(.ENERGY_W(8), .ATTACK_W(8), .HANG_W(16), .EVENT_W(16)) u_dut_a (
        .Clk_780k (clk),
        .Reset    (rst),
        .sq       (sq_a.slave)
    );

    energy_squelch #(.ENERGY_W(8), .ATTACK_W(8), .HANG_W(16), .EVENT_W(2)) u_dut_b (
        .Clk_780k (clk),
        .Reset    (rst),
        .sq       (sq_b.slave)
    );

    typedef struct {
        bit is_open;
        int idx;
        int peak;
        int ev;
        int evsat;
    } exp_t;

    exp_t q_exp[$];
    exp_t e_cur;
    int   n_checks = 0;
    int   n_errors = 0;
    int   idx = 0;

    task automatic chk(input string name, input longint act, input longint req);
        n_checks++;
        if (act != req) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (sample %0d)", name, act, req, idx);
        end
    endtask

    task automatic cfg(input int on_t, input int off_t, input int att, input int hang);
        sq_a.OnThreshold  = 8'(on_t);  sq_b.OnThreshold  = 8'(on_t);
        sq_a.OffThreshold = 8'(off_t); sq_b.OffThreshold = 8'(off_t);
        sq_a.AttackCount  = 8'(att);   sq_b.AttackCount  = 8'(att);
        sq_a.HangCount    = 16'(hang); sq_b.HangCount    = 16'(hang);
    endtask

    task automatic step(input int e);
        sq_a.Energy = 8'(e);
        sq_b.Energy = 8'(e);
        @(posedge clk);
        #1;
        idx++;
    endtask

    task automatic steps(input int e, input int n);
        for (int i = 0; i < n; i++) step(e);
    endtask

    // Expected event produced by the next sample to be stepped
    task automatic exp_ev(input bit is_open, input int peak, input int ev, input int evsat);
        exp_t x;
        x.is_open = is_open;
        x.idx     = idx;
        x.peak    = peak;
        x.ev      = ev;
        x.evsat   = evsat;
        q_exp.push_back(x);
    endtask

    always @(negedge clk) begin
        if (sq_a.OpenPulse || sq_a.ClosePulse) begin
            if (q_exp.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL spurious_event: open_pulse=%0b close_pulse=%0b with nothing expected (sample %0d)",
                         sq_a.OpenPulse, sq_a.ClosePulse, idx - 1);
            end else begin
                e_cur = q_exp.pop_front();
                chk("event_kind_open_pulse", longint'(sq_a.OpenPulse), longint'(e_cur.is_open));
                chk("event_kind_close_pulse", longint'(sq_a.ClosePulse), longint'(!e_cur.is_open));
                chk("event_sample_index", longint'(idx - 1), longint'(e_cur.idx));
                chk("event_peak", longint'(sq_a.Peak), longint'(e_cur.peak));
                chk("event_count", longint'(sq_a.EventCount), longint'(e_cur.ev));
                chk("event_count_sat2", longint'(sq_b.EventCount), longint'(e_cur.evsat));
                chk("event_open_level", longint'(sq_a.Open), longint'(e_cur.is_open));
                chk("sat2_open_pulse", longint'(sq_b.OpenPulse), longint'(e_cur.is_open));
            end
        end
    end

    initial begin
        cfg(100, 80, 3, 4);
        rst = 1'b1;
        steps(200, 3);
        chk("reset_open", longint'(sq_a.Open), 0);
        chk("reset_peak", longint'(sq_a.Peak), 0);
        chk("reset_event_count", longint'(sq_a.EventCount), 0);
        chk("reset_event_count_sat2", longint'(sq_b.EventCount), 0);
        rst = 1'b0;

        steps(200, 2);
        chk("attack_not_done_open", longint'(sq_a.Open), 0);
        exp_ev(1'b1, 200, 1, 1); step(200);
        chk("attack_done_open", longint'(sq_a.Open), 1);
        steps(70, 3);
        chk("hang_still_open", longint'(sq_a.Open), 1);
        exp_ev(1'b0, 200, 1, 1); step(70);

        step(50);
        steps(120, 2);
        exp_ev(1'b1, 120, 2, 2); step(120);

        step(70); step(70); step(90);
        chk("hang_recover_open", longint'(sq_a.Open), 1);
        step(150); step(130);
        steps(70, 3);
        exp_ev(1'b0, 150, 2, 2); step(70);
        step(50);
        chk("peak_held_closed", longint'(sq_a.Peak), 150);

        step(120); step(120); step(90);
        chk("attack_abort_closed", longint'(sq_a.Open), 0);
        step(120); step(120);
        exp_ev(1'b1, 120, 3, 3); step(120);

        steps(70, 3);
        cfg(100, 80, 3, 2);
        exp_ev(1'b0, 120, 3, 3); step(70);

        cfg(100, 80, 0, 0);
        step(99);
        chk("below_on_threshold", longint'(sq_a.Open), 0);
        exp_ev(1'b1, 100, 4, 3); step(100);
        step(80);
        chk("at_off_threshold_open", longint'(sq_a.Open), 1);
        exp_ev(1'b0, 100, 4, 3); step(79);

        exp_ev(1'b1, 101, 5, 3); step(101);
        rst = 1'b1;
        step(101);
        rst = 1'b0;
        chk("midrun_reset_open", longint'(sq_a.Open), 0);
        chk("midrun_reset_peak", longint'(sq_a.Peak), 0);
        chk("midrun_reset_event_count", longint'(sq_a.EventCount), 0);
        steps(0, 3);

        chk("scoreboard_drained", longint'(q_exp.size()), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
